// File: rtl/sqrt_sched.sv
// sqrt_sched -- shares one iterative square-root core among NREQ requesters.
//
// One operation is in flight at a time. Requesters present a radicand with
// req_valid and hold it until req_ready (a one-hot grant) pulses for their
// lane. The scheduler then issues one core_start pulse. It waits for
// core_valid, or gives up after TIMEOUT cycles in WAIT, and then presents the
// result on the rsp_* handshake.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid[NREQ]        per-lane request, held with data until granted
//   req_rad[NREQ*WIDTH]    lane i radicand in bits [i*WIDTH +: WIDTH]
//   req_ready[NREQ]        one-hot grant, combinational in IDLE only
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 lane that owns the response
//   rsp_root/rsp_rem       core result (both 0 when rsp_err is set)
//   rsp_err                the core did not answer within TIMEOUT cycles
//   core_start             single-cycle start pulse to the core
//   core_rad               radicand to the core, held for the whole operation
//   core_valid/root/rem    core result, core_valid is a one-cycle pulse
//   sched_busy             high whenever the FSM is not idle
//
// FBITS only documents the Q-format of the data (Q(WIDTH-FBITS).FBITS).
// No arithmetic in this block depends on it.
module sqrt_sched #(
  parameter int WIDTH   = 32,
  parameter int FBITS   = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_rad,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_root,
  output logic [WIDTH-1:0]        rsp_rem,
  output logic                    rsp_err,
  output logic                    core_start,
  output logic [WIDTH-1:0]        core_rad,
  input  logic                    core_valid,
  input  logic [WIDTH-1:0]        core_root,
  input  logic [WIDTH-1:0]        core_rem,
  output logic                    sched_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [IDW-1:0]   owner_reg, owner_next;
  logic [WIDTH-1:0] core_rad_reg, core_rad_next;
  logic [IDW-1:0]   rsp_id_reg, rsp_id_next;
  logic [WIDTH-1:0] rsp_root_reg, rsp_root_next;
  logic [WIDTH-1:0] rsp_rem_reg, rsp_rem_next;
  logic             rsp_err_reg, rsp_err_next;

  logic             win_found;
  logic [IDW-1:0]   win_idx;

  // Unpack the flat radicand bus into one word per lane.
  logic [WIDTH-1:0] rad_lane [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign rad_lane[gi] = req_rad[gi*WIDTH +: WIDTH];
  end

  // Lane index base+off wrapped modulo NREQ. NREQ need not be a power of two,
  // so a plain bit truncation would not wrap correctly.
  function automatic logic [IDW-1:0] lane_at(input logic [IDW-1:0] base,
                                             input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Round-robin pick. The scan starts at ptr_reg and the first active lane
  // wins. Lanes that drop req_valid before a grant are skipped.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[lane_at(ptr_reg, k)]) begin
        win_found = 1'b1;
        win_idx   = lane_at(ptr_reg, k);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    owner_next    = owner_reg;
    core_rad_next = core_rad_reg;
    rsp_id_next   = rsp_id_reg;
    rsp_root_next = rsp_root_reg;
    rsp_rem_next  = rsp_rem_reg;
    rsp_err_next  = rsp_err_reg;
    req_ready     = '0;
    core_start    = 1'b0;
    rsp_valid     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // The grant is gated by reset_n. A requester that sees req_ready
        // drops its request, so the grant must not be shown while reset
        // discards the registers it would load.
        if (win_found && reset_n) begin
          req_ready     = NREQ'(1) << win_idx;
          owner_next    = win_idx;
          core_rad_next = rad_lane[win_idx];
          ptr_next      = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          state_next    = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // If core_valid lands in the last allowed cycle, it still wins over
        // the timeout.
        if (core_valid) begin
          rsp_id_next   = owner_reg;
          rsp_root_next = core_root;
          rsp_rem_next  = core_rem;
          rsp_err_next  = 1'b0;
          state_next    = S_RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rsp_id_next   = owner_reg;
          rsp_root_next = '0;
          rsp_rem_next  = '0;
          rsp_err_next  = 1'b1;
          state_next    = S_RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      owner_reg    <= '0;
      core_rad_reg <= '0;
      rsp_id_reg   <= '0;
      rsp_root_reg <= '0;
      rsp_rem_reg  <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      owner_reg    <= owner_next;
      core_rad_reg <= core_rad_next;
      rsp_id_reg   <= rsp_id_next;
      rsp_root_reg <= rsp_root_next;
      rsp_rem_reg  <= rsp_rem_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  assign sched_busy = (state_reg != S_IDLE);
  assign core_rad   = core_rad_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_root   = rsp_root_reg;
  assign rsp_rem    = rsp_rem_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched -- randomized self-checking bench for sqrt_sched.
//
// The bench contains a behavioural sqrt core with a programmable latency,
// including a "never answers" setting. A transaction-level reference model
// predicts the following for every cycle:
//   - which lane is granted (round-robin pointer arithmetic)
//   - when core_start and rsp_valid appear
//   - the response contents, using floor(sqrt(rad << 16)), or an error
//     response when the latency exceeds TIMEOUT
module tb_sqrt_sched;
  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*WIDTH-1:0]   req_rad = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [WIDTH-1:0]        rsp_root, rsp_rem;
  logic                    rsp_err;
  logic                    core_start;
  logic [WIDTH-1:0]        core_rad;
  logic                    core_valid = 1'b0;
  logic [WIDTH-1:0]        core_root = '0, core_rem = '0;
  logic                    sched_busy;

  sqrt_sched #(.WIDTH(WIDTH), .FBITS(16), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rad(req_rad),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .core_start(core_start), .core_rad(core_rad), .core_valid(core_valid),
    .core_root(core_root), .core_rem(core_rem), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus and reference-model state.
  logic [WIDTH-1:0] lane_rad [NREQ];
  int   cyc = 0;
  bit   op_active = 0;
  int   g_cycle = 0, resp_cycle = 0, op_lat = 0, next_lat = 8;
  int   exp_id = 0, last_id = 0, exp_ptr = 0, grant_lane = -1;
  logic [WIDTH-1:0] exp_rad = '0, exp_root = '0, exp_rem = '0;
  logic [WIDTH-1:0] last_root = '0, last_rem = '0;
  bit   exp_err = 0, last_err = 0;
  int   grant_log[$];
  int   served = 0, start_cnt = 0;
  int   obs_id = 0;
  logic [WIDTH-1:0] obs_root = '0, obs_rem = '0;
  bit   obs_err = 0;
  bit   start_seen = 0;
  int   cd = 0;
  logic [WIDTH-1:0] core_latched = '0;
  bit   auto_req = 0, auto_ready = 0, auto_lat = 0, refill = 0, stray_now = 0;

  // floor(sqrt(x)) for x < 2^48.
  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = 64'd0;
    for (int b = 24; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic pack_rad();
    for (int i = 0; i < NREQ; i++) req_rad[i*WIDTH +: WIDTH] = lane_rad[i];
  endtask

  // Called at the falling edge. Compares every output against the model and
  // advances the model by one cycle.
  task automatic model_cycle();
    int w;
    bit in_resp;
    logic [63:0] sq, r;
    start_seen = core_start;
    if (core_start) start_cnt++;
    in_resp = 0;
    if (!op_active) begin
      w = rr_pick(req_valid, exp_ptr);
      chk("busy_idle", 64'(sched_busy), 64'd0);
      chk("start_idle", 64'(core_start), 64'd0);
      chk("rspv_idle", 64'(rsp_valid), 64'd0);
      chk("req_ready", 64'(req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
      if (w >= 0) begin
        op_active = 1;
        g_cycle   = cyc;
        exp_id    = w;
        exp_rad   = lane_rad[w];
        op_lat    = next_lat;
        if (op_lat > TIMEOUT) begin
          exp_root   = '0;
          exp_rem    = '0;
          exp_err    = 1;
          resp_cycle = cyc + 2 + TIMEOUT;
        end else begin
          sq         = 64'(exp_rad) << 16;
          r          = isqrt(sq);
          exp_root   = WIDTH'(r);
          exp_rem    = WIDTH'(sq - r * r);
          exp_err    = 0;
          resp_cycle = cyc + 2 + op_lat;
        end
        exp_ptr    = (w + 1) % NREQ;
        grant_lane = w;
        grant_log.push_back(w);
      end
    end else begin
      in_resp = (cyc >= resp_cycle);
      chk("busy_active", 64'(sched_busy), 64'd1);
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      chk("core_start", 64'(core_start), 64'(cyc == g_cycle + 1));
      chk("core_rad", 64'(core_rad), 64'(exp_rad));
      chk("rsp_valid", 64'(rsp_valid), 64'(in_resp));
      if (in_resp) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_id));
        chk("rsp_root", 64'(rsp_root), 64'(exp_root));
        chk("rsp_rem", 64'(rsp_rem), 64'(exp_rem));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        if (rsp_ready) begin
          obs_id   = int'(rsp_id);
          obs_root = rsp_root;
          obs_rem  = rsp_rem;
          obs_err  = rsp_err;
          $display("txn %0d: lane=%0d rad=%h root=%h rem=%h err=%0d lat=%0d",
                   served, obs_id, exp_rad, obs_root, obs_rem, obs_err, op_lat);
          op_active = 0;
          last_id   = exp_id;
          last_root = exp_root;
          last_rem  = exp_rem;
          last_err  = exp_err;
          served++;
        end
      end
    end
    if (!in_resp) begin
      chk("hold_id", 64'(rsp_id), 64'(last_id));
      chk("hold_root", 64'(rsp_root), 64'(last_root));
      chk("hold_rem", 64'(rsp_rem), 64'(last_rem));
      chk("hold_err", 64'(rsp_err), 64'(last_err));
    end
  endtask

  // Called just after the rising edge. Updates requesters, the consumer and
  // the behavioural core.
  task automatic drive_cycle();
    logic [63:0] sq, r;
    cyc++;
    if (grant_lane >= 0) begin
      if (refill) lane_rad[grant_lane] = $urandom;
      else req_valid[grant_lane] = 1'b0;
      grant_lane = -1;
    end
    if (auto_req) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            lane_rad[i]  = $urandom;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (auto_ready) rsp_ready = ($urandom_range(0, 2) != 0);
    if (auto_lat) begin
      case ($urandom_range(0, 9))
        0: next_lat = TIMEOUT;
        1: next_lat = TIMEOUT + 1;
        2: next_lat = NEVER;
        default: next_lat = $urandom_range(1, 30);
      endcase
    end
    pack_rad();
    if (start_seen) begin
      core_latched = core_rad;
      cd = op_lat;
    end else if (cd > 0) begin
      cd--;
    end
    start_seen = 0;
    core_valid = (cd == 1);
    if (core_valid) begin
      sq = 64'(core_latched) << 16;
      r  = isqrt(sq);
      core_root = WIDTH'(r);
      core_rem  = WIDTH'(sq - r * r);
    end else begin
      core_root = $urandom;
      core_rem  = $urandom;
    end
    if (stray_now) begin
      core_valid = 1'b1;
      stray_now  = 0;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_core_start"}, 64'(core_start), 64'd0);
    chk({tag, "_busy"}, 64'(sched_busy), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_root"}, 64'(rsp_root), 64'd0);
    chk({tag, "_rsp_rem"}, 64'(rsp_rem), 64'd0);
    chk({tag, "_core_rad"}, 64'(core_rad), 64'd0);
  endtask

  // Asserts reset partway through a cycle and checks the outputs right away.
  // It then resets the model and releases reset just after a rising edge.
  task automatic pulse_reset(input int hold);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    op_active  = 0;
    exp_ptr    = 0;
    last_id    = 0;
    last_root  = '0;
    last_rem   = '0;
    last_err   = 0;
    grant_lane = -1;
    grant_log.delete();
    cd         = 0;
    start_seen = 0;
    core_valid = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      cyc++;
      pack_rad();
    end
    reset_n = 1'b1;
  endtask

  task automatic wait_served(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (served < target && b > 0) begin
      run_cycle();
      b--;
    end
    chk(tag, 64'(served), 64'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int b;
    b = budget;
    while (op_active && b > 0) begin
      run_cycle();
      b--;
    end
    chk(tag, 64'(op_active), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int b;
    logic [63:0] sq;
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) lane_rad[i] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    reset_n = 1'b1;

    // Lane 0, 4.0 -> 2.0 with a 24-cycle core.
    rsp_ready = 1'b1;
    next_lat = 24;
    lane_rad[0] = 32'h0004_0000;
    req_valid = 4'b0001;
    pack_rad();
    wait_served("a_served", served + 1, 200);
    chk("a_root", 64'(obs_root), 64'h0002_0000);
    chk("a_rem", 64'(obs_rem), 64'd0);
    chk("a_id", 64'(obs_id), 64'd0);
    chk("a_err", 64'(obs_err), 64'd0);

    // Lane 2, 2.0 -> 1.41421; exactly one start pulse.
    start_cnt = 0;
    lane_rad[2] = 32'h0002_0000;
    req_valid = 4'b0100;
    pack_rad();
    wait_served("b_served", served + 1, 200);
    chk("b_root", 64'(obs_root), 64'h0001_6A09);
    chk("b_rem", 64'(obs_rem), 64'd166831);
    chk("b_id", 64'(obs_id), 64'd2);
    chk("b_starts", 64'(start_cnt), 64'd1);

    // All lanes request from reset: round-robin order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) lane_rad[i] = $urandom;
    req_valid = 4'b1111;
    refill = 1;
    next_lat = 3;
    pack_rad();
    pulse_reset(2);
    b = 400;
    while (grant_log.size() < 5 && b > 0) begin
      run_cycle();
      b--;
    end
    chk("c_grants", 64'(grant_log.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++)
      chk("c_order", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(order[k]));
    refill = 0;
    req_valid = '0;
    pack_rad();
    wait_idle("c_idle", 200);

    // Core never answers: error response, then a normal one.
    lane_rad[1] = $urandom;
    req_valid = 4'b0010;
    next_lat = NEVER;
    pack_rad();
    wait_served("d_served_to", served + 1, 300);
    chk("d_err", 64'(obs_err), 64'd1);
    chk("d_root0", 64'(obs_root), 64'd0);
    chk("d_rem0", 64'(obs_rem), 64'd0);
    chk("d_id", 64'(obs_id), 64'd1);
    lane_rad[3] = $urandom;
    req_valid = 4'b1000;
    next_lat = 5;
    pack_rad();
    wait_served("d_served_ok", served + 1, 300);
    sq = 64'(lane_rad[3]) << 16;
    chk("d_err_clear", 64'(obs_err), 64'd0);
    chk("d_root_ok", 64'(obs_root), isqrt(sq) & 64'hFFFF_FFFF);

    // Consumer stalls 10 cycles in RESP while another lane waits. A stray
    // core_valid is injected during the stall.
    rsp_ready = 1'b0;
    lane_rad[0] = $urandom;
    lane_rad[2] = $urandom;
    req_valid = 4'b0101;
    next_lat = 4;
    pack_rad();
    b = 100;
    while (!(op_active && cyc >= resp_cycle) && b > 0) begin
      run_cycle();
      b--;
    end
    chk("e_in_resp", 64'(rsp_valid), 64'd1);
    start_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) stray_now = 1;
      run_cycle();
    end
    chk("e_no_start", 64'(start_cnt), 64'd0);
    rsp_ready = 1'b1;
    wait_served("e_served", served + 2, 300);

    // Reset during WAIT: the operation is dropped and lowest active lane wins.
    lane_rad[0] = $urandom;
    req_valid = 4'b0001;
    next_lat = 20;
    pack_rad();
    b = 60;
    while (!(op_active && cyc == g_cycle + 5) && b > 0) begin
      run_cycle();
      b--;
    end
    chk("f_in_wait", 64'(sched_busy), 64'd1);
    lane_rad[1] = $urandom;
    lane_rad[3] = $urandom;
    req_valid = 4'b1010;
    next_lat = 6;
    pack_rad();
    pulse_reset(3);
    wait_served("f_served", served + 2, 400);
    chk("f_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd1);

    // Random traffic.
    auto_req = 1;
    auto_ready = 1;
    auto_lat = 1;
    wait_served("g_served", served + 120, 20000);
    auto_req = 0;
    auto_ready = 0;
    auto_lat = 0;
    rsp_ready = 1'b1;
    next_lat = 3;
    req_valid = '0;
    pack_rad();
    wait_idle("g_idle", 500);
    repeat (4) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
